// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - hazard detection and operand forwarding control beside ID
//
// Purpose: tracks destination registers of the DEPTH instructions downstream of ID
// (stage 1 = EX ... stage DEPTH = WB), selects the youngest forwarding source for
// each ID operand, stalls on load-use, flushes on taken branch and keeps saturating
// stall/flush event counters.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   id_valid                     ID holds a real instruction
//   id_rs, id_rt                 source register addresses
//   id_uses_rs, id_uses_rt       operand is actually read
//   id_reg_write, id_mem_read    instruction writes a register / is a load
//   id_dest                      destination register
//   branch_taken                 branch/jump resolved taken in EX
//   fwd_sel_rs, fwd_sel_rt       0 = register file, k = result of stage k
//   stall                        hold PC and IF/ID, bubble into EX
//   flush_if_id, flush_id_ex     squash IF/ID and the instruction entering EX
//   stall_count, flush_count     saturating event counters

module pipe_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int SEL_W      = $clog2(DEPTH + 1),
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  branch_taken,
    output logic [SEL_W-1:0]      fwd_sel_rs,
    output logic [SEL_W-1:0]      fwd_sel_rt,
    output logic                  stall,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    // Tracker, indexed by stage number 1..DEPTH
    logic [DEPTH:1]        valid_q, valid_d;
    logic [DEPTH:1]        wr_q, wr_d;
    logic [DEPTH:1]        load_q, load_d;
    logic [REG_ADDR_W-1:0] dest_q [1:DEPTH];
    logic [REG_ADDR_W-1:0] dest_d [1:DEPTH];

    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    logic [DEPTH:1]        match_rs;
    logic [DEPTH:1]        match_rt;
    logic [SEL_W-1:0]      sel_rs;
    logic [SEL_W-1:0]      sel_rt;
    logic                  load_use;
    logic                  branch_live;
    logic                  stall_int;
    logic                  bubble_in;

    // Register 0 is hard-wired and never forwarded; unread operands never match.
    always_comb begin
        match_rs = '0;
        match_rt = '0;
        for (int s = 1; s <= DEPTH; s++) begin
            match_rs[s] = id_valid && id_uses_rs && (id_rs != '0) &&
                          valid_q[s] && wr_q[s] && (dest_q[s] == id_rs);
            match_rt[s] = id_valid && id_uses_rt && (id_rt != '0) &&
                          valid_q[s] && wr_q[s] && (dest_q[s] == id_rt);
        end
    end

    // Walk from oldest to youngest so the youngest match is the last one written.
    always_comb begin
        sel_rs = '0;
        sel_rt = '0;
        for (int s = DEPTH; s >= 1; s--) begin
            if (match_rs[s]) begin
                sel_rs = SEL_W'(s);
            end
            if (match_rt[s]) begin
                sel_rt = SEL_W'(s);
            end
        end
    end

    // Only a load sitting in EX is too late to forward; one stage later it forwards from MEM.
    assign load_use    = (match_rs[1] | match_rt[1]) & load_q[1];
    // Inputs are ignored during reset, including the branch request.
    assign branch_live = branch_taken & rst_n;
    assign stall_int   = load_use & ~branch_live;
    assign bubble_in   = stall_int | branch_live | ~id_valid;

    assign fwd_sel_rs  = sel_rs;
    assign fwd_sel_rt  = sel_rt;
    assign stall       = stall_int;
    assign flush_if_id = branch_live;
    assign flush_id_ex = branch_live;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

    always_comb begin
        valid_d = valid_q;
        wr_d    = wr_q;
        load_d  = load_q;
        for (int s = 1; s <= DEPTH; s++) begin
            dest_d[s] = dest_q[s];
        end

        for (int s = 2; s <= DEPTH; s++) begin
            valid_d[s] = valid_q[s-1];
            wr_d[s]    = wr_q[s-1];
            load_d[s]  = load_q[s-1];
            dest_d[s]  = dest_q[s-1];
        end

        if (bubble_in) begin
            valid_d[1] = 1'b0;
            wr_d[1]    = 1'b0;
            load_d[1]  = 1'b0;
            dest_d[1]  = '0;
        end else begin
            valid_d[1] = 1'b1;
            wr_d[1]    = id_reg_write;
            load_d[1]  = id_mem_read;
            dest_d[1]  = id_dest;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_int && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (branch_live && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            wr_q        <= '0;
            load_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            for (int s = 1; s <= DEPTH; s++) begin
                dest_q[s] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            wr_q        <= wr_d;
            load_q      <= load_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            for (int s = 1; s <= DEPTH; s++) begin
                dest_q[s] <= dest_d[s];
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - self-checking bench for pipe_hazard_unit

module tb_pipe_hazard_unit;

    localparam int RW    = 5;
    localparam int DEPTH = 3;
    localparam int SEL_W = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [RW-1:0]    id_rs;
    logic [RW-1:0]    id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_reg_write;
    logic             id_mem_read;
    logic [RW-1:0]    id_dest;
    logic             branch_taken;
    logic [SEL_W-1:0] fwd_sel_rs;
    logic [SEL_W-1:0] fwd_sel_rt;
    logic             stall;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    pipe_hazard_unit #(
        .REG_ADDR_W(RW),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_reg_write(id_reg_write),
        .id_mem_read (id_mem_read),
        .id_dest     (id_dest),
        .branch_taken(branch_taken),
        .fwd_sel_rs  (fwd_sel_rs),
        .fwd_sel_rt  (fwd_sel_rt),
        .stall       (stall),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic          urs;
        logic          urt;
        logic          rw;
        logic          mr;
        logic [RW-1:0] dest;
        logic          br;
        logic [SEL_W-1:0] e_rs;
        logic [SEL_W-1:0] e_rt;
        logic          e_stall;
        logic          e_flush;
    } vec_t;

    typedef struct {
        logic [SEL_W-1:0] e_rs;
        logic [SEL_W-1:0] e_rt;
        logic             e_stall;
        logic             e_flush;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_sc   = 0;
    int   exp_fc   = 0;

    function automatic vec_t mk(input logic v, input int rs, input int rt,
                                input logic urs, input logic urt, input logic rw,
                                input logic mr, input int dest, input logic br,
                                input int ers, input int ert, input logic es,
                                input logic ef);
        vec_t r;
        r.v = v; r.rs = RW'(rs); r.rt = RW'(rt); r.urs = urs; r.urt = urt;
        r.rw = rw; r.mr = mr; r.dest = RW'(dest); r.br = br;
        r.e_rs = SEL_W'(ers); r.e_rt = SEL_W'(ert); r.e_stall = es; r.e_flush = ef;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        id_valid     = v.v;
        id_rs        = v.rs;
        id_rt        = v.rt;
        id_uses_rs   = v.urs;
        id_uses_rt   = v.urt;
        id_reg_write = v.rw;
        id_mem_read  = v.mr;
        id_dest      = v.dest;
        branch_taken = v.br;
        e.e_rs = v.e_rs; e.e_rt = v.e_rt; e.e_stall = v.e_stall; e.e_flush = v.e_flush;
        sb.push_back(e);
    endtask

    task automatic compare_comb(input string tag, output exp_t e);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
            e.e_rs = '0; e.e_rt = '0; e.e_stall = 1'b0; e.e_flush = 1'b0;
        end else begin
            e = sb.pop_front();
            check({tag, " fwd_sel_rs"}, 32'(fwd_sel_rs), 32'(e.e_rs));
            check({tag, " fwd_sel_rt"}, 32'(fwd_sel_rt), 32'(e.e_rt));
            check({tag, " stall"}, 32'(stall), 32'(e.e_stall));
            check({tag, " flush_if_id"}, 32'(flush_if_id), 32'(e.e_flush));
            check({tag, " flush_id_ex"}, 32'(flush_id_ex), 32'(e.e_flush));
        end
    endtask

    // One ID cycle: drive after the edge, compare combinational outputs mid-cycle,
    // then compare the counters after the following edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        drive(v);
        @(negedge clk);
        compare_comb(tag, e);
        @(posedge clk);
        #1;
        if (e.e_stall && exp_sc < CMAX) exp_sc++;
        if (e.e_flush && exp_fc < CMAX) exp_fc++;
        check({tag, " stall_count"}, 32'(stall_count), 32'(exp_sc));
        check({tag, " flush_count"}, 32'(flush_count), 32'(exp_fc));
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_dest = '0; branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n  = 1'b0;
        exp_sc = 0;
        exp_fc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // v rs rt urs urt rw mr dest br | e_rs e_rt e_stall e_flush
        vecs.push_back(mk(1,  1,  2, 1, 1, 1, 0,  3, 0, 0, 0, 0, 0)); // add r3<-r1,r2
        vecs.push_back(mk(1,  3,  1, 1, 1, 1, 0,  6, 0, 1, 0, 0, 0)); // sub reads r3 @EX
        vecs.push_back(mk(1,  2,  3, 1, 1, 1, 0,  7, 0, 0, 2, 0, 0)); // r3 @MEM
        vecs.push_back(mk(1,  3,  6, 1, 1, 1, 0,  8, 0, 3, 2, 0, 0)); // r3 @WB still forwards
        vecs.push_back(mk(1,  0,  0, 1, 0, 1, 1,  5, 0, 0, 0, 0, 0)); // lw r5
        vecs.push_back(mk(1,  1,  5, 1, 1, 1, 0,  9, 0, 0, 1, 1, 0)); // load-use stall
        vecs.push_back(mk(1,  1,  5, 1, 1, 1, 0,  9, 0, 0, 2, 0, 0)); // held, load @MEM
        vecs.push_back(mk(1,  1,  1, 1, 0, 1, 0,  4, 0, 0, 0, 0, 0)); // writer r4
        vecs.push_back(mk(1,  2,  2, 1, 0, 1, 0,  4, 0, 0, 0, 0, 0)); // writer r4 again
        vecs.push_back(mk(1,  4,  9, 1, 1, 1, 0, 10, 0, 1, 3, 0, 0)); // youngest r4 wins
        vecs.push_back(mk(1,  1,  2, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0)); // writer r0
        vecs.push_back(mk(1,  0,  0, 1, 1, 1, 0, 11, 0, 0, 0, 0, 0)); // reads r0: no match
        vecs.push_back(mk(1, 11, 10, 0, 1, 1, 0, 12, 0, 0, 3, 0, 0)); // rs unused
        vecs.push_back(mk(0, 12,  0, 1, 0, 1, 0, 13, 0, 0, 0, 0, 0)); // id_valid=0
        vecs.push_back(mk(1, 12,  0, 1, 0, 0, 0,  0, 0, 2, 0, 0, 0)); // non-writer
        vecs.push_back(mk(1,  1,  0, 1, 0, 1, 1, 13, 0, 0, 0, 0, 0)); // lw r13
        vecs.push_back(mk(1, 13,  1, 1, 1, 1, 0, 14, 1, 1, 0, 0, 1)); // load-use + branch
        vecs.push_back(mk(1, 13, 14, 1, 1, 1, 0, 16, 0, 2, 0, 0, 0)); // squashed r14 gone
        vecs.push_back(mk(1, 16,  0, 1, 0, 1, 1, 15, 0, 1, 0, 0, 0)); // lw r15 reads ALU r16
        vecs.push_back(mk(1, 15, 16, 1, 1, 1, 0, 17, 0, 1, 2, 1, 0)); // load-use on rs
        vecs.push_back(mk(0, 15, 16, 1, 1, 1, 0, 17, 0, 0, 0, 0, 0)); // idle ID
        vecs.push_back(mk(1, 15,  0, 1, 0, 1, 0, 18, 0, 3, 0, 0, 0)); // lw r15 @WB

        idle_inputs();
        rst_n        = 1'b0;
        branch_taken = 1'b1;
        id_valid     = 1'b1;
        #12;
        check("reset fwd_sel_rs", 32'(fwd_sel_rs), 32'd0);
        check("reset fwd_sel_rt", 32'(fwd_sel_rt), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        check("reset flush_if_id", 32'(flush_if_id), 32'd0);
        check("reset flush_id_ex", 32'(flush_id_ex), 32'd0);
        check("reset stall_count", 32'(stall_count), 32'd0);
        check("reset flush_count", 32'(flush_count), 32'd0);
        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Stall counter saturation: 17 load-use pairs on a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) begin
            apply(mk(1, 0, 0, 1, 0, 1, 1, 5, 0, 0, 0, 0, 0), $sformatf("sat%0d lw", i));
            apply(mk(1, 1, 5, 1, 1, 1, 0, 9, 0, 0, 1, 1, 0), $sformatf("sat%0d use", i));
            apply(mk(1, 1, 5, 1, 1, 1, 0, 9, 0, 0, 2, 0, 0), $sformatf("sat%0d held", i));
        end
        check("stall_count saturated", 32'(stall_count), 32'(CMAX));

        // Flush counter saturation
        for (int i = 0; i < 17; i++) begin
            apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), $sformatf("fsat%0d", i));
        end
        check("flush_count saturated", 32'(flush_count), 32'(CMAX));

        // Reset asserted while a load-use stall is active
        apply(mk(1, 0, 0, 1, 0, 1, 1, 5, 0, 0, 0, 0, 0), "mid lw");
        drive(mk(1, 1, 5, 1, 1, 1, 0, 9, 0, 0, 1, 1, 0));
        @(negedge clk);
        compare_comb("mid use", e);
        #2;
        rst_n = 1'b0;
        exp_sc = 0;
        exp_fc = 0;
        #1;
        check("async stall", 32'(stall), 32'd0);
        check("async fwd_sel_rt", 32'(fwd_sel_rt), 32'd0);
        check("async stall_count", 32'(stall_count), 32'd0);
        check("async flush_count", 32'(flush_count), 32'd0);
        branch_taken = 1'b1;
        #1;
        check("in-reset flush_if_id", 32'(flush_if_id), 32'd0);
        @(posedge clk);
        #1;
        check("in-reset flush_count", 32'(flush_count), 32'd0);
        @(negedge clk);
        branch_taken = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply(mk(1, 5, 5, 1, 1, 1, 0, 20, 0, 0, 0, 0, 0), "post-reset empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Hazard and forwarding controller for the pipelined successor of the single-cycle datapath.
- Sits beside the ID stage. Tracks destination registers of in-flight instructions across a parametrised number of downstream stages.
- Drives operand-forwarding selects, load-use stall and branch flush.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- REG_ADDR_W, 5, register-address width.
- DEPTH, 3, tracked stages after ID (1=EX, 2=MEM, ..., DEPTH=WB). Legal range 2..8.
- SEL_W, $clog2(DEPTH+1), width of forwarding selects.
- CNT_W, 16, width of event counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_ADDR_W  source register 1
- id_rt  in  REG_ADDR_W  source register 2
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_reg_write  in  1  instruction writes a register
- id_mem_read  in  1  instruction is a load
- id_dest  in  REG_ADDR_W  destination register (already muxed rd/rt)
- branch_taken  in  1  branch/jump resolved taken in EX this cycle
- fwd_sel_rs  out  SEL_W  rs operand source: 0=register file, k=result of stage k
- fwd_sel_rt  out  SEL_W  rt operand source, same encoding as fwd_sel_rs
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- flush_if_id  out  1  squash IF/ID contents
- flush_id_ex  out  1  squash instruction entering EX
- stall_count  out  CNT_W  cycles stalled, saturating
- flush_count  out  CNT_W  flush events, saturating

Behaviour:
- Tracker: per stage s=1..DEPTH holds valid, wr, load, dest. Reset (async, rst_n=0) clears every valid bit and both counters. With the tracker empty, all outputs are 0.
- Match rule: stage s matches operand r when all of the following hold:
  - valid[s] and wr[s];
  - dest[s]==r;
  - r!=0;
  - the operand's uses_* bit is 1;
  - id_valid is 1.
  Register 0 never matches.
- fwd_sel_x (combinational): lowest-numbered (youngest) matching s, else 0. A match at s=DEPTH still forwards, so no RF write-through is required.
- Load-use (combinational): the younger of matches for rs/rt is s=1 with load[1]=1.
- stall = load_use & ~branch_taken.
- flush_if_id = flush_id_ex = branch_taken. Branch wins over stall when both occur in the same cycle.
- Shift at each rising edge (rst_n=1): stage s+1 <= stage s for s=1..DEPTH-1; stage DEPTH's contents retire.
- Stage 1 load value at each edge:
  - If stall or branch_taken or ~id_valid: loads a bubble (valid=0).
  - Otherwise: loads {1, id_reg_write, id_mem_read, id_dest}.
- Latency:
  - A load stalls exactly one cycle. On the next cycle it sits at s=2 and fwd_sel=2.
  - Forward select is valid in the same cycle the ID inputs are valid.
- stall_count increments on each cycle with stall=1. flush_count increments on each cycle with branch_taken=1. Both hold at 2^CNT_W-1 and never wrap.
- Reset asserted mid-stall: outputs drop to 0 asynchronously. The tracker is empty after release.
- Inputs are ignored while rst_n=0.

Test Plan:
- Reset, then ID add r3<-r1,r2; next cycle ID sub reads r3 -> fwd_sel_rs=1, stall=0. Following cycle, another instruction reads r3 -> fwd_sel=2.
- lw r5; next ID add reads r5 -> stall=1 for exactly 1 cycle, stall_count=1, EX gets bubble. Next cycle fwd_sel_rt=2, stall=0.
- Two writers of r4 at stages 1 and 2, ID reads r4 -> fwd_sel_rs=1 (youngest wins).
- Writer with dest=r0, ID reads r0 -> fwd_sel=0, no stall.
- Load-use hazard and branch_taken=1 in the same cycle -> stall=0, flush_if_id=flush_id_ex=1, flush_count=1, stage 1 bubble.
- Force stall_count to 2^CNT_W-1 (CNT_W=4 build, 16 stalls) -> holds at 15. rst_n pulse low mid-stall -> counters 0, stall=0 immediately.
